// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and one-hot word results.
// Results are encoded {lt, gt, eq}.
package serial_magnitude_comparator_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_t;

   localparam logic [2:0] ResEq = 3'b001;
   localparam logic [2:0] ResGt = 3'b010;
   localparam logic [2:0] ResLt = 3'b100;

   function automatic logic is_onehot3(logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

endpackage

// File: rtl/serial_magnitude_comparator_shreg.sv
// Loadable left-shift register exposing its MSB; one instance per operand.
module serial_magnitude_comparator_shreg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= din;
      end else if (shift) begin
         data_q <= {data_q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Word-level magnitude comparator: streams operand bits MSB first to an external
// 1-bit comparator and folds its eq/gt/lt answers into a word result.
module serial_magnitude_comparator
   import serial_magnitude_comparator_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             bit_a,
   output logic             bit_b,
   input  logic             cmp_eq,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             neq,
   output logic             gt,
   output logic             lt,
   output logic             err
);

   localparam int unsigned CntW = $clog2(WIDTH);

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      pend_q, pend_d;
   logic [2:0]      res_q, res_d;
   logic            err_q, err_d;
   logic            decided_q, decided_d;
   logic            load, shift;
   logic [2:0]      cmp_vec;

   assign cmp_vec = {cmp_lt, cmp_gt, cmp_eq};

   serial_magnitude_comparator_shreg #(
      .WIDTH(WIDTH)
   ) u_shreg_a (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shift(shift),
      .din  (a),
      .msb  (bit_a)
   );

   serial_magnitude_comparator_shreg #(
      .WIDTH(WIDTH)
   ) u_shreg_b (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shift(shift),
      .din  (b),
      .msb  (bit_b)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      res_d     = res_q;
      err_d     = err_q;
      decided_d = decided_q;
      load      = 1'b0;
      shift     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               load      = 1'b1;
               cnt_d     = CntW'(WIDTH - 1);
               pend_d    = ResEq;
               decided_d = 1'b0;
               err_d     = 1'b0;
               state_d   = StShift;
            end
         end
         StShift: begin
            shift = 1'b1;
            cnt_d = cnt_q - 1'b1;
            // A malformed answer counts as an equal bit: flag it, keep the decision untouched.
            if (!is_onehot3(cmp_vec)) begin
               err_d = 1'b1;
            end else if (!decided_q && (cmp_gt || cmp_lt)) begin
               pend_d    = cmp_gt ? ResGt : ResLt;
               decided_d = 1'b1;
            end
            if ((cnt_q == '0) || (EARLY_EXIT && decided_d)) begin
               res_d   = pend_d;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         pend_q    <= ResEq;
         res_q     <= ResEq;
         err_q     <= 1'b0;
         decided_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         res_q     <= res_d;
         err_q     <= err_d;
         decided_q <= decided_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign eq   = res_q[0];
   assign gt   = res_q[1];
   assign lt   = res_q[2];
   assign neq  = ~res_q[0];
   assign err  = err_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench: an early-exit and a full-scan comparator, each wired to a behavioural 1-bit
// comparator, driven with directed and random operands and checked every cycle.
module tb_serial_magnitude_comparator;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         force_bad;

   logic bit_a_e, bit_b_e, cmp_eq_e, cmp_gt_e, cmp_lt_e;
   logic busy_e, done_e, eq_e, neq_e, gt_e, lt_e, err_e;
   logic bit_a_f, bit_b_f, cmp_eq_f, cmp_gt_f, cmp_lt_f;
   logic busy_f, done_f, eq_f, neq_f, gt_f, lt_f, err_f;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [2:0] prev_res;

   always #5 clk = ~clk;

   // 1-bit comparators; force_bad drives the illegal eq=gt=1 answer.
   assign cmp_eq_e = force_bad ? 1'b1 : (bit_a_e == bit_b_e);
   assign cmp_gt_e = force_bad ? 1'b1 : (bit_a_e & ~bit_b_e);
   assign cmp_lt_e = force_bad ? 1'b0 : (~bit_a_e & bit_b_e);
   assign cmp_eq_f = force_bad ? 1'b1 : (bit_a_f == bit_b_f);
   assign cmp_gt_f = force_bad ? 1'b1 : (bit_a_f & ~bit_b_f);
   assign cmp_lt_f = force_bad ? 1'b0 : (~bit_a_f & bit_b_f);

   serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .bit_a(bit_a_e), .bit_b(bit_b_e),
      .cmp_eq(cmp_eq_e), .cmp_gt(cmp_gt_e), .cmp_lt(cmp_lt_e),
      .busy(busy_e), .done(done_e), .eq(eq_e), .neq(neq_e), .gt(gt_e), .lt(lt_e), .err(err_e)
   );

   serial_magnitude_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .bit_a(bit_a_f), .bit_b(bit_b_f),
      .cmp_eq(cmp_eq_f), .cmp_gt(cmp_gt_f), .cmp_lt(cmp_lt_f),
      .busy(busy_f), .done(done_f), .eq(eq_f), .neq(neq_f), .gt(gt_f), .lt(lt_f), .err(err_f)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Expected word result {lt, gt, eq}.
   function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
      if (x > y) return 3'b010;
      if (x < y) return 3'b100;
      return 3'b001;
   endfunction

   // Early-exit done cycle: first differing bit at MSB offset i finishes in cycle i+2.
   function automatic int ref_done_early(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      d = x ^ y;
      for (int i = 0; i < W; i++) begin
         if (d[W-1-i]) return i + 2;
      end
      return W + 1;
   endfunction

   task automatic check_dut(input string tag, input int which, input int c, input int exp_cyc,
                            input logic [2:0] nr, input logic [W-1:0] ao, input logic [W-1:0] bo,
                            input int bad);
      logic       bs, dn, e, n, g, l, er, ba, bb;
      logic [2:0] xr;
      string      t;
      if (which == 0) {bs, dn, e, n, g, l, er, ba, bb} =
         {busy_e, done_e, eq_e, neq_e, gt_e, lt_e, err_e, bit_a_e, bit_b_e};
      else            {bs, dn, e, n, g, l, er, ba, bb} =
         {busy_f, done_f, eq_f, neq_f, gt_f, lt_f, err_f, bit_a_f, bit_b_f};
      t  = $sformatf("%s/%s/c%0d", tag, (which == 0) ? "early" : "full", c);
      xr = (c >= exp_cyc) ? nr : prev_res;
      chk({t, " busy"}, bs, c <= exp_cyc);
      chk({t, " done"}, dn, c == exp_cyc);
      chk({t, " eq"}, e, xr[0]);
      chk({t, " neq"}, n, ~xr[0]);
      chk({t, " gt"}, g, xr[1]);
      chk({t, " lt"}, l, xr[2]);
      chk({t, " err"}, er, (bad > 0) && (c > bad));
      if (c < exp_cyc) begin
         chk({t, " bit_a"}, ba, ao[W-c]);
         chk({t, " bit_b"}, bb, bo[W-c]);
      end
   endtask

   // One compare from cycle 0 (start) through cycle W+3; bad>0 corrupts cmp_* in that cycle.
   task automatic run(input string tag, input logic [W-1:0] ao, input logic [W-1:0] bo,
                      input int bad, input bit extra);
      logic [W-1:0] am, bm;
      logic [2:0]   nr;
      int           ce;
      am = ao;
      bm = bo;
      if (bad > 0) begin
         am[W-bad] = 1'b0;
         bm[W-bad] = 1'b0;
      end
      nr = ref_res(am, bm);
      ce = ref_done_early(am, bm);
      @(negedge clk);
      start = 1'b1;
      a     = ao;
      b     = bo;
      for (int c = 1; c <= W + 3; c++) begin
         @(negedge clk);
         start     = extra && (c == 3 || c == 9);
         a         = W'($urandom);
         b         = W'($urandom);
         force_bad = (c == bad);
         check_dut(tag, 0, c, ce, nr, ao, bo, bad);
         check_dut(tag, 1, c, W + 1, nr, ao, bo, bad);
      end
      start     = 1'b0;
      force_bad = 1'b0;
      prev_res  = nr;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " busy_e"}, busy_e, 1'b0);
      chk({tag, " done_e"}, done_e, 1'b0);
      chk({tag, " eq_e"}, eq_e, 1'b1);
      chk({tag, " neq_e"}, neq_e, 1'b0);
      chk({tag, " gt_e"}, gt_e, 1'b0);
      chk({tag, " lt_e"}, lt_e, 1'b0);
      chk({tag, " err_e"}, err_e, 1'b0);
      chk({tag, " bit_a_e"}, bit_a_e, 1'b0);
      chk({tag, " bit_b_e"}, bit_b_e, 1'b0);
      chk({tag, " busy_f"}, busy_f, 1'b0);
      chk({tag, " done_f"}, done_f, 1'b0);
      chk({tag, " eq_f"}, eq_f, 1'b1);
      chk({tag, " neq_f"}, neq_f, 1'b0);
      chk({tag, " gt_f"}, gt_f, 1'b0);
      chk({tag, " lt_f"}, lt_f, 1'b0);
      chk({tag, " err_f"}, err_f, 1'b0);
      chk({tag, " bit_a_f"}, bit_a_f, 1'b0);
      chk({tag, " bit_b_f"}, bit_b_f, 1'b0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst       = 1'b1;
      start     = 1'b0;
      force_bad = 1'b0;
      a         = '0;
      b         = '0;
      prev_res  = 3'b001;
      #1;
      check_reset_values("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run("eq_5a", 8'h5A, 8'h5A, 0, 1'b0);
      run("gt_80_7f", 8'h80, 8'h7F, 0, 1'b0);
      run("lt_01_02", 8'h01, 8'h02, 0, 1'b0);
      ra = W'($urandom);
      run("busy_start", ra, ra, 0, 1'b1);

      // Reset in cycle 4 of a 00 vs FF compare.
      @(negedge clk);
      start = 1'b1;
      a     = 8'h00;
      b     = 8'hFF;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_values("mid_rst");
      prev_res = 3'b001;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < W + 2; c++) begin
         @(negedge clk);
         chk($sformatf("mid_rst no done_e c%0d", c), done_e, 1'b0);
         chk($sformatf("mid_rst no done_f c%0d", c), done_f, 1'b0);
      end
      run("after_rst", 8'hC3, 8'h3C, 0, 1'b0);

      ra = W'($urandom);
      rb = W'($urandom);
      run("bad_cmp", ra, rb, 1, 1'b0);
      run("err_clear", 8'h10, 8'h11, 0, 1'b0);

      for (int k = 0; k < 30; k++) begin
         ra = W'($urandom);
         unique case (k % 3)
            0: rb = ra;
            1: rb = ra ^ (W'(1) << $urandom_range(W - 1, 0));
            default: rb = W'($urandom);
         endcase
         run($sformatf("rnd%0d", k), ra, rb, 0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
